// File: rtl/core_pkg.sv
// Shared types and constants for the execute/memory boundary.
//   XLEN          datapath width of result, store data, PC and target
//   REG_AW        register-file address width
//   exmem_entry_t one EX->MEM pipeline entry (valid bit travels with payload)
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } exmem_entry_t;

endpackage

// File: rtl/skid_reg.sv
// Generic two-entry valid/ready skid buffer.
// Main register M drives the output; skid register S catches one entry that
// arrives while M is full and not being consumed. in_ready depends only on
// S occupancy, so the upstream ready path is a plain register output.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   in_valid       upstream offers in_data
//   in_ready       buffer can take an entry this cycle (S empty)
//   in_data        incoming payload
//   out_valid      M holds an entry
//   out_ready      downstream consumes M this cycle
//   out_data       M payload
//   skid_valid     S holds an entry
module skid_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rstn,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data,
    output logic skid_valid
);

    logic m_valid;
    logic s_valid;
    T     m_data;
    T     s_data;
    logic in_fire;
    logic m_free;

    assign in_ready   = ~s_valid;
    assign in_fire    = in_valid & in_ready;
    assign m_free     = ~m_valid | out_ready;
    assign out_valid  = m_valid;
    assign out_data   = m_data;
    assign skid_valid = s_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (m_free) begin
            if (s_valid) begin
                // in_ready is low here, so no new entry can be lost
                m_data  <= s_data;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (in_fire) begin
                m_data  <= in_data;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_fire) begin
            s_data  <= in_data;
            s_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures finished ALU/FPU results into a skid
// buffer toward the memory stage and raises the fetch redirect / ID-EX flush
// for taken branches at the moment the branch is accepted.
// Optional macro EXMEM_PERF_EN adds stall_cycles and taken_branches counters.
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   ex_valid, alu_ready               EX holds an instruction / result final
//   alu_result_ex, store_data_ex      payload from EX
//   rd_ex, reg_write_ex, mem_read_ex, mem_write_ex   control from EX
//   branch_alu, branch_target_ex      taken branch and its target
//   ex_stall                          hold EX and earlier stages
//   data_ready_mem, mem_valid         handshake with memory stage
//   alu_result_mem .. mem_write_mem   registered payload to memory stage
//   pc_redirect, pc_target            one-cycle redirect to fetch
//   flush_id_ex                       kill younger instructions
//   stall_cycles, taken_branches      counters (EXMEM_PERF_EN only)
module ex_mem_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
`ifdef EXMEM_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_valid,
    input  logic              alu_ready,
    input  logic [XLEN-1:0]   alu_result_ex,
    input  logic              branch_alu,
    input  logic [XLEN-1:0]   branch_target_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic              mem_write_ex,
    input  logic [XLEN-1:0]   store_data_ex,
    output logic              ex_stall,
    input  logic              data_ready_mem,
    output logic              mem_valid,
    output logic [XLEN-1:0]   alu_result_mem,
    output logic [XLEN-1:0]   store_data_mem,
    output logic [REG_AW-1:0] rd_mem,
    output logic              reg_write_mem,
    output logic              mem_read_mem,
    output logic              mem_write_mem,
    output logic              pc_redirect,
    output logic [XLEN-1:0]   pc_target,
    output logic              flush_id_ex
`ifdef EXMEM_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  taken_branches
`endif
);

    import core_pkg::*;

    exmem_entry_t entry_in;
    exmem_entry_t entry_m;
    logic         in_valid;
    logic         ex_ready;
    logic         ex_fire;
    logic         m_valid;
    logic         s_valid;

    always_comb begin
        entry_in            = '0;
        entry_in.valid      = 1'b1;
        entry_in.result     = alu_result_ex;
        entry_in.store_data = store_data_ex;
        entry_in.rd         = rd_ex;
        entry_in.reg_write  = reg_write_ex;
        entry_in.mem_read   = mem_read_ex;
        entry_in.mem_write  = mem_write_ex;
    end

    assign in_valid = ex_valid & alu_ready;
    assign ex_fire  = in_valid & ex_ready;

    skid_reg #(.T(exmem_entry_t)) u_skid (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (ex_ready),
        .in_data    (entry_in),
        .out_valid  (m_valid),
        .out_ready  (data_ready_mem),
        .out_data   (entry_m),
        .skid_valid (s_valid)
    );

    // The stored valid bit is 1 for every loaded entry and 0 after reset,
    // so gating with it is equivalent to the buffer's occupancy flag alone.
    assign mem_valid      = m_valid & entry_m.valid;
    assign alu_result_mem = entry_m.result;
    assign store_data_mem = entry_m.store_data;
    assign rd_mem         = entry_m.rd;
    assign reg_write_mem  = entry_m.reg_write;
    assign mem_read_mem   = entry_m.mem_read;
    assign mem_write_mem  = entry_m.mem_write;

    assign ex_stall = s_valid | (ex_valid & ~alu_ready);

    // Redirect fires on acceptance so memory backpressure never delays it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_redirect <= 1'b0;
            pc_target   <= '0;
        end else begin
            pc_redirect <= ex_fire & branch_alu;
            if (ex_fire & branch_alu) begin
                pc_target <= branch_target_ex;
            end
        end
    end

    assign flush_id_ex = pc_redirect;

`ifdef EXMEM_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cycles   <= '0;
            taken_branches <= '0;
        end else begin
            if (ex_stall) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (pc_redirect) begin
                taken_branches <= taken_branches + 1'b1;
            end
        end
    end
`else
    // Counters absent in this build.
`endif

endmodule
